// File: rtl/mem_wait_responder_if.sv
// Load/store handshake between a core port (master) and a wait-state memory responder (slave).
interface mem_wait_responder_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  request;
    logic                  we_re;
    logic [3:0]            mask;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           data_in;
    logic                  load;
    logic                  valid;
    logic [31:0]           data_out;
    logic                  busy;

    modport master (
        output request, we_re, mask, address, data_in, load,
        input  valid, data_out, busy
    );

    modport slave (
        input  request, we_re, mask, address, data_in, load,
        output valid, data_out, busy
    );
endinterface

// File: rtl/mem_wait_responder.sv
// Single-outstanding memory responder: captures a request, waits LATENCY cycles,
// then performs a byte-masked write or masked read and pulses valid for one cycle.
module mem_wait_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2,
    parameter int INIT_ZERO  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_wait_responder_if.slave   bus
);

    // INIT_ZERO is only range-checked; the array is never cleared in hardware.
    if (LATENCY < 1 || LATENCY > 15 || INIT_ZERO < 0 || INIT_ZERO > 1) begin : g_bad_params
        $error("mem_wait_responder: LATENCY must be 1..15 and INIT_ZERO 0 or 1");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    state_t                next_state;
    logic [3:0]            count;
    logic [3:0]            next_count;
    logic                  accept;
    logic                  enter_resp;

    logic                  cmd_we;
    logic                  cmd_load;
    logic [3:0]            cmd_mask;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [31:0]           cmd_data;

    logic                  op_we;
    logic                  op_load;
    logic [3:0]            op_mask;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [31:0]           op_data;
    logic [31:0]           byte_mask;

    logic [31:0]           data_out_q;
    logic [31:0]           mem [0:(1 << ADDR_WIDTH) - 1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    always_comb begin
        next_state = state;
        next_count = count;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (bus.request) begin
                    accept     = 1'b1;
                    next_count = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        next_state = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (count <= 4'd1) begin
                    next_state = RESP;
                    enter_resp = 1'b1;
                end else begin
                    next_count = count - 4'd1;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_we   <= 1'b0;
            cmd_load <= 1'b0;
            cmd_mask <= '0;
            cmd_addr <= '0;
            cmd_data <= '0;
        end else if (accept) begin
            cmd_we   <= bus.we_re;
            cmd_load <= bus.load;
            cmd_mask <= bus.mask;
            cmd_addr <= bus.address;
            cmd_data <= bus.data_in;
        end
    end

    // With LATENCY=1 the access happens on the acceptance edge itself, so the
    // live inputs stand in for the not-yet-captured command.
    always_comb begin
        op_we   = accept ? bus.we_re   : cmd_we;
        op_load = accept ? bus.load    : cmd_load;
        op_mask = accept ? bus.mask    : cmd_mask;
        op_addr = accept ? bus.address : cmd_addr;
        op_data = accept ? bus.data_in : cmd_data;
        for (int i = 0; i < 4; i++) begin
            byte_mask[8*i +: 8] = {8{op_mask[i]}};
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && op_we) begin
            for (int i = 0; i < 4; i++) begin
                if (op_mask[i]) begin
                    mem[op_addr][8*i +: 8] <= op_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_q <= '0;
        end else if (enter_resp && !op_we && op_load) begin
            data_out_q <= mem[op_addr] & byte_mask;
        end
    end

    assign bus.valid    = (state == RESP);
    assign bus.busy     = (state != IDLE);
    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder: one LATENCY=2 and one LATENCY=1 instance,
// read data checked against a reference memory through an expected-value queue.
module tb_mem_wait_responder;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] model_mem [2][256];
    logic [31:0] last_out [2];
    logic [31:0] expected_q [$];

    always #5 clk = ~clk;

    mem_wait_responder_if #(.ADDR_WIDTH(8)) bus_a ();
    mem_wait_responder_if #(.ADDR_WIDTH(8)) bus_b ();

    mem_wait_responder #(.ADDR_WIDTH(8), .LATENCY(2), .INIT_ZERO(0)) dut_a (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_a.slave)
    );

    mem_wait_responder #(.ADDR_WIDTH(8), .LATENCY(1), .INIT_ZERO(0)) dut_b (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_b.slave)
    );

    function automatic logic [31:0] expand(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    function automatic logic get_valid(input bit sel);
        return sel ? bus_b.valid : bus_a.valid;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? bus_b.busy : bus_a.busy;
    endfunction

    function automatic logic [31:0] get_data(input bit sel);
        return sel ? bus_b.data_out : bus_a.data_out;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic req, input logic we, input logic [3:0] m,
                         input logic [7:0] a, input logic [31:0] d, input logic ld);
        if (sel) begin
            bus_b.request = req; bus_b.we_re = we; bus_b.mask = m;
            bus_b.address = a;   bus_b.data_in = d; bus_b.load = ld;
        end else begin
            bus_a.request = req; bus_a.we_re = we; bus_a.mask = m;
            bus_a.address = a;   bus_a.data_in = d; bus_a.load = ld;
        end
    endtask

    // Reference memory update and scoreboard push at the moment of acceptance.
    task automatic model_accept(input bit sel, input logic we, input logic [3:0] m,
                                input logic [7:0] a, input logic [31:0] d, input logic ld);
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (m[i]) model_mem[sel][a][8*i +: 8] = d[8*i +: 8];
        end else if (ld) begin
            expected_q.push_back(model_mem[sel][a] & expand(m));
        end
    endtask

    task automatic checkResponse(input bit sel, input string tag, input logic we, input logic ld);
        logic [31:0] exp;
        if (!we && ld) begin
            checkOutput({tag, " queue"}, 32'(expected_q.size() > 0), 32'd1);
            exp = (expected_q.size() > 0) ? expected_q.pop_front() : 32'hXXXX_XXXX;
            checkOutput({tag, " data"}, get_data(sel), exp);
            last_out[sel] = exp;
        end else begin
            checkOutput({tag, " data held"}, get_data(sel), last_out[sel]);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic we, input logic [3:0] m,
                                 input logic [7:0] a, input logic [31:0] d, input logic ld,
                                 input string tag);
        int edges;
        int lat;
        lat = sel ? 1 : 2;
        @(negedge clk);
        drive(sel, 1'b1, we, m, a, d, ld);
        model_accept(sel, we, m, a, d, ld);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, ~we, ~m, ~a, ~d, ~ld);
        checkOutput({tag, " busy"}, 32'(get_busy(sel)), 32'd1);
        edges = 0;
        while (!get_valid(sel) && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput({tag, " latency"}, 32'(edges), 32'(lat - 1));
        if (edges < 20) begin
            checkResponse(sel, tag, we, ld);
            @(posedge clk);
            #1;
            checkOutput({tag, " valid drop"}, 32'(get_valid(sel)), 32'd0);
            checkOutput({tag, " busy drop"}, 32'(get_busy(sel)), 32'd0);
        end
    endtask

    initial begin
        logic exp_valid [7];
        logic exp_busy [7];
        exp_valid = '{0, 1, 0, 0, 1, 0, 0};
        exp_busy  = '{1, 1, 0, 1, 1, 0, 0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
        last_out[0] = 32'h0;
        last_out[1] = 32'h0;
        #12;
        for (int s = 0; s < 2; s++) begin
            checkOutput("reset valid", 32'(get_valid(s[0])), 32'd0);
            checkOutput("reset busy", 32'(get_busy(s[0])), 32'd0);
            checkOutput("reset data_out", get_data(s[0]), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b0, 1'b1, 4'hF, 8'h04, 32'hDEADBEEF, 1'b0, "full write");
        applyStimulus(1'b0, 1'b0, 4'hF, 8'h04, 32'h0, 1'b1, "full read");
        applyStimulus(1'b0, 1'b1, 4'b0101, 8'h04, 32'h11223344, 1'b0, "partial write");
        applyStimulus(1'b0, 1'b0, 4'hF, 8'h04, 32'h0, 1'b1, "merged read");
        applyStimulus(1'b0, 1'b0, 4'b0011, 8'h04, 32'h0, 1'b1, "masked read");

        $display("[TB] request held high for six cycles");
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 4'hF, 8'h04, 32'h0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            if (k == 0 || k == 3) model_accept(1'b0, 1'b0, 4'hF, 8'h04, 32'h0, 1'b1);
            #1;
            checkOutput($sformatf("hold valid c%0d", k), 32'(bus_a.valid), 32'(exp_valid[k]));
            checkOutput($sformatf("hold busy c%0d", k), 32'(bus_a.busy), 32'(exp_busy[k]));
            if (exp_valid[k]) checkResponse(1'b0, $sformatf("hold resp c%0d", k), 1'b0, 1'b1);
            if (k == 5) drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
        end

        applyStimulus(1'b0, 1'b0, 4'hF, 8'h04, 32'h0, 1'b0, "read no load");
        applyStimulus(1'b0, 1'b1, 4'h0, 8'h04, 32'hFFFFFFFF, 1'b0, "zero-mask write");
        applyStimulus(1'b0, 1'b0, 4'hF, 8'h04, 32'h0, 1'b1, "after zero-mask read");

        applyStimulus(1'b0, 1'b1, 4'hF, 8'h10, 32'h12345678, 1'b0, "preload 10");
        $display("[TB] reset during WAIT aborts a write");
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 4'hF, 8'h10, 32'hCAFEF00D, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
        checkOutput("abort busy before", 32'(bus_a.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort valid", 32'(bus_a.valid), 32'd0);
        checkOutput("abort busy", 32'(bus_a.busy), 32'd0);
        checkOutput("abort data_out", bus_a.data_out, 32'h0);
        last_out[0] = 32'h0;
        last_out[1] = 32'h0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'hF, 8'h10, 32'h0, 1'b1, "read after abort");

        applyStimulus(1'b1, 1'b1, 4'hF, 8'hFF, 32'hA5A50001, 1'b0, "L1 write 1");
        applyStimulus(1'b1, 1'b0, 4'hF, 8'hFF, 32'h0, 1'b1, "L1 read 1");
        applyStimulus(1'b1, 1'b1, 4'b1100, 8'hFF, 32'h0BADCAFE, 1'b0, "L1 write 2");
        applyStimulus(1'b1, 1'b0, 4'hF, 8'hFF, 32'h0, 1'b1, "L1 read 2");
        applyStimulus(1'b1, 1'b1, 4'b0001, 8'hFF, 32'h00000077, 1'b0, "L1 write 3");
        applyStimulus(1'b1, 1'b0, 4'hF, 8'hFF, 32'h0, 1'b1, "L1 read 3");

        checkOutput("scoreboard drained", 32'(expected_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
